// File: rtl/bios_loader_pkg.sv
// Shared types and constants for the boot/debug command processor.
//   opcode_e  : command byte values accepted on the serial link
//   state_e   : command processor states
//   ACK_*     : single-byte replies
//   STAT_*    : bit positions inside the STATUS reply byte
package bios_loader_pkg;

  typedef enum logic [7:0] {
    OP_NOP      = 8'h00,
    OP_BOOT     = 8'h01,
    OP_RST      = 8'h02,
    OP_SET_ADDR = 8'h03,
    OP_WRITE    = 8'h04,
    OP_READ     = 8'h05,
    OP_STATUS   = 8'h06
  } opcode_e;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ARGS,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_TX,
    ST_CONSOLE
  } state_e;

  localparam logic [7:0] ACK_OK  = 8'h00;
  localparam logic [7:0] ACK_ERR = 8'hEE;

  localparam int STAT_CPU_RST    = 0;
  localparam int STAT_FIFO_EMPTY = 1;
  localparam int STAT_OVERFLOW   = 2;

endpackage

// File: rtl/bios_loader_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
//   push/din  : write side; a push while full is dropped unless a pop
//               happens in the same cycle
//   pop/dout  : read side; dout shows the head entry whenever !empty
//   full/empty: registered status flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + (AW+1)'(1);
    else if (!do_push && do_pop) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/bios_loader.sv
// Boot/debug command processor between a byte serial link and a RAM port.
//   clk, rst_n            : clock, async active-low reset
//   i_ebreak              : CPU breakpoint, returns to command mode from console
//   o_cpu_rst, o_booted   : CPU reset hold / CPU running
//   o_mem_*, i_mem_*      : word RAM port, req held until gnt, rvalid later
//   i_rx_*, o_rx_ready    : command byte input
//   o_tx_*, i_tx_ready    : reply / console byte output
//   i_con_*, o_con_full   : CPU console byte input into an internal FIFO
module bios_loader
  import bios_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CON_DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_ebreak,
  output logic                    o_cpu_rst,
  output logic                    o_booted,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_gnt,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  input  logic [7:0]              i_con_data,
  input  logic                    i_con_valid,
  output logic                    o_con_full
);
  localparam int         AB      = ADDR_WIDTH/8;
  localparam int         DB      = DATA_WIDTH/8;
  localparam logic [3:0] AB_LAST = 4'(AB-1);
  localparam logic [3:0] DB_LAST = 4'(DB-1);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, tx_buf;
  logic [3:0]            arg_cnt, tx_cnt;
  logic                  arg_is_write, boot_pend, ebreak_pend;
  logic                  cpu_rst, booted, overflow, mem_we;
  logic                  fifo_full, fifo_empty, fifo_pop, console_exit;
  logic [7:0]            fifo_dout, status;

  sync_fifo #(.WIDTH(8), .DEPTH(CON_DEPTH)) u_con_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (i_con_valid),
    .din   (i_con_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_pop    = (state == ST_CONSOLE) && !fifo_empty && i_tx_ready;
  assign o_con_full  = fifo_full;
  assign o_cpu_rst   = cpu_rst;
  assign o_booted    = booted;
  assign o_mem_we    = mem_we;
  assign o_mem_addr  = addr;
  assign o_mem_wdata = wdata;
  assign o_mem_be    = '1;

  always_comb begin
    status                  = '0;
    status[STAT_CPU_RST]    = cpu_rst;
    status[STAT_FIFO_EMPTY] = fifo_empty;
    status[STAT_OVERFLOW]   = overflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CMD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_rx_ready   = 1'b0;
    o_tx_valid   = 1'b0;
    o_tx_data    = tx_buf[7:0];
    o_mem_req    = 1'b0;
    console_exit = 1'b0;
    case (state)
      ST_CMD: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) begin
          case (i_rx_data)
            OP_SET_ADDR, OP_WRITE: state_nxt = ST_ARGS;
            OP_READ:               state_nxt = ST_MEM_REQ;
            default:               state_nxt = ST_TX;
          endcase
        end
      end
      ST_ARGS: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid && arg_cnt == (arg_is_write ? DB_LAST : AB_LAST))
          state_nxt = arg_is_write ? ST_MEM_REQ : ST_TX;
      end
      ST_MEM_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) state_nxt = mem_we ? ST_TX : ST_MEM_WAIT;
      end
      ST_MEM_WAIT: if (i_mem_rvalid) state_nxt = ST_TX;
      ST_TX: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready && tx_cnt == '0) state_nxt = boot_pend ? ST_CONSOLE : ST_CMD;
      end
      ST_CONSOLE: begin
        o_tx_valid = !fifo_empty;
        o_tx_data  = fifo_dout;
        // Leave only once no byte is stuck mid-handshake on tx.
        console_exit = (i_ebreak || ebreak_pend) && !(!fifo_empty && !i_tx_ready);
        if (console_exit) state_nxt = ST_CMD;
      end
      default: state_nxt = ST_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      wdata        <= '0;
      tx_buf       <= '0;
      arg_cnt      <= '0;
      tx_cnt       <= '0;
      arg_is_write <= 1'b0;
      boot_pend    <= 1'b0;
      ebreak_pend  <= 1'b0;
      cpu_rst      <= 1'b1;
      booted       <= 1'b0;
      overflow     <= 1'b0;
      mem_we       <= 1'b0;
    end else begin
      case (state)
        ST_CMD: if (i_rx_valid) begin
          arg_cnt <= '0;
          tx_cnt  <= '0;
          tx_buf  <= DATA_WIDTH'(ACK_OK);
          case (i_rx_data)
            OP_NOP:      ;
            OP_BOOT:     boot_pend <= 1'b1;
            OP_RST:      cpu_rst <= 1'b1;
            OP_SET_ADDR: arg_is_write <= 1'b0;
            OP_WRITE:    begin arg_is_write <= 1'b1; mem_we <= 1'b1; end
            OP_READ:     mem_we <= 1'b0;
            OP_STATUS:   begin tx_buf <= DATA_WIDTH'(status); overflow <= 1'b0; end
            default:     tx_buf <= DATA_WIDTH'(ACK_ERR);
          endcase
        end
        ST_ARGS: if (i_rx_valid) begin
          // Little-endian: each byte enters at the top and shifts down.
          arg_cnt <= arg_cnt + 4'd1;
          if (arg_is_write) wdata <= (wdata >> 8) | (DATA_WIDTH'(i_rx_data) << (DATA_WIDTH-8));
          else              addr  <= (addr >> 8)  | (ADDR_WIDTH'(i_rx_data) << (ADDR_WIDTH-8));
        end
        ST_MEM_REQ: if (i_mem_gnt) addr <= addr + ADDR_WIDTH'(DB);
        ST_MEM_WAIT: if (i_mem_rvalid) begin
          tx_buf <= i_mem_rdata;
          tx_cnt <= DB_LAST;
        end
        ST_TX: if (i_tx_ready) begin
          tx_buf <= tx_buf >> 8;
          tx_cnt <= tx_cnt - 4'd1;
          if (tx_cnt == '0 && boot_pend) begin
            boot_pend <= 1'b0;
            cpu_rst   <= 1'b0;
            booted    <= 1'b1;
          end
        end
        ST_CONSOLE: begin
          if (console_exit) begin
            ebreak_pend <= 1'b0;
            booted      <= 1'b0;
            cpu_rst     <= 1'b1;
          end else if (i_ebreak) begin
            ebreak_pend <= 1'b1;
          end
        end
        default: ;
      endcase
      // A dropped push wins over the STATUS clear in the same cycle.
      if (i_con_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end
endmodule
